// File: rtl/amp3_i2s_rx.sv
// amp3_i2s_rx: I2S slave receiver. BCLK/LRCLK/SDATA are synchronised into clk.
// Ports: clk, rst, enable, BCLK, LRCLK, SDATA in; dataL, dataR, valid, RightNLeft, error out.
module amp3_i2s_rx #(
  parameter int DATASIZE = 12,
  parameter int SLOTMAX  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                BCLK,
  input  logic                LRCLK,
  input  logic                SDATA,
  output logic [DATASIZE-1:0] dataL,
  output logic [DATASIZE-1:0] dataR,
  output logic                valid,
  output logic                RightNLeft,
  output logic                error
);

  localparam int CW = $clog2(SLOTMAX + 1);

  typedef enum logic {
    IDLE,
    RX
  } state_t;

  state_t state, state_n;

  logic [1:0] bclk_sy, lr_sy, sd_sy;
  logic bclk_d, ev, lr_q, sd_q;
  logic lr_prev, lhave, chg;
  logic [CW-1:0] cnt;
  logic [DATASIZE-1:0] shift, shift_n, shadow;

  // Synchroniser, then a registered rising-edge detect of BCLK.
  // LRCLK/SDATA get the same extra stage so they stay aligned with ev.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sy <= '0;
      lr_sy   <= '0;
      sd_sy   <= '0;
      bclk_d  <= 1'b0;
      ev      <= 1'b0;
      lr_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      bclk_sy <= {bclk_sy[0], BCLK};
      lr_sy   <= {lr_sy[0], LRCLK};
      sd_sy   <= {sd_sy[0], SDATA};
      bclk_d  <= bclk_sy[1];
      ev      <= bclk_sy[1] & ~bclk_d;
      lr_q    <= lr_sy[1];
      sd_q    <= sd_sy[1];
    end
  end

  assign chg = ev & (lr_q != lr_prev);

  // Current word with this event's bit placed MSB-first; bits past
  // DATASIZE match no position and are dropped.
  always_comb begin
    shift_n = shift;
    for (int i = 0; i < DATASIZE; i++) begin
      if (cnt == CW'(DATASIZE - 1 - i)) shift_n[i] = sd_q;
    end
  end

  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else if (chg) state_n = RX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      shadow     <= '0;
      lhave      <= 1'b0;
      lr_prev    <= 1'b0;
      dataL      <= '0;
      dataR      <= '0;
      valid      <= 1'b0;
      RightNLeft <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_n;
      valid <= 1'b0;
      if (ev) lr_prev <= lr_q;
      if (!enable) begin
        cnt   <= '0;
        shift <= '0;
        lhave <= 1'b0;
        error <= 1'b0;
      end else if (chg) begin
        cnt        <= '0;
        shift      <= '0;
        RightNLeft <= lr_q;
        if (state == RX) begin
          // cnt+1 bits committed; fewer than DATASIZE is a short slot
          if (cnt < CW'(DATASIZE - 1)) error <= 1'b1;
          if (!RightNLeft) begin
            shadow <= shift_n;
            lhave  <= 1'b1;
          end else if (lhave) begin
            dataR <= shift_n;
            dataL <= shadow;
            valid <= 1'b1;
            lhave <= 1'b0;
          end
        end else begin
          lhave <= 1'b0;
        end
      end else if (ev && state == RX) begin
        shift <= shift_n;
        if (cnt != CW'(SLOTMAX)) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
